// File: rtl/ex_stage_if.sv
// ID/EX payload and EX/WB result handshake bundle for ex_stage.
interface ex_stage_if #(
  parameter int XLEN = 32
);
  // Upstream payload (valid/ready)
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_addr;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            reg_wen_in;

  // Downstream result (valid/ready)
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] reg_wdata;
  logic [4:0]      reg_waddr;
  logic            reg_wen;
  logic            illegal;

  // The execute stage itself
  modport slave (
    input  in_valid, instr, instr_addr, operand1, operand2, reg_wen_in, out_ready,
    output in_ready, out_valid, reg_wdata, reg_waddr, reg_wen, illegal
  );

  // The agent feeding the stage and draining its results
  modport master (
    output in_valid, instr, instr_addr, operand1, operand2, reg_wen_in, out_ready,
    input  in_ready, out_valid, reg_wdata, reg_waddr, reg_wen, illegal
  );
endinterface

// File: rtl/ex_stage.sv
// Integer execute stage: ALU for OP/OP-IMM/LUI/AUIPC with a registered
// result and either a barrel shifter or a 1-bit-per-cycle iterative shifter.
module ex_stage #(
  parameter int XLEN       = 32,
  parameter int SHIFT_MODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  output logic       busy,
  ex_stage_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {IDLE, SHIFT, OUT} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] wdata_reg;
  logic [4:0]      waddr_reg;
  logic            wen_reg;
  logic            illegal_reg;
  logic [SHW-1:0]  count_reg;
  logic            shift_left_reg;
  logic            shift_arith_reg;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic            alt;
  logic [XLEN-1:0] op_a, op_b;
  logic [SHW-1:0]  shamt;
  logic            is_alu, legal, is_shift, iterative, accept;
  logic [XLEN-1:0] sra_result;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] shift_step;
  logic            unused_bits;

  assign opcode = bus.instr[6:0];
  assign rd     = bus.instr[11:7];
  assign funct3 = bus.instr[14:12];
  assign alt    = bus.instr[30];
  assign op_a   = bus.operand1;
  assign op_b   = bus.operand2;
  assign shamt  = bus.operand2[SHW-1:0];
  // Register-source and remaining immediate fields are resolved by decode.
  assign unused_bits = ^{bus.instr[31], bus.instr[29:15]};

  assign is_alu   = (opcode == OPC_OP_IMM) || (opcode == OPC_OP);
  assign legal    = is_alu || (opcode == OPC_LUI) || (opcode == OPC_AUIPC);
  assign is_shift = is_alu && ((funct3 == 3'b001) || (funct3 == 3'b101));
  // A zero-distance shift takes the single-cycle path even in iterative mode.
  assign iterative = (SHIFT_MODE == 1) && is_shift && (shamt != '0);

  assign bus.in_ready  = (state_reg == IDLE) || ((state_reg == OUT) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready && !flush;
  assign bus.out_valid = (state_reg == OUT);
  assign busy          = (state_reg == SHIFT);
  assign bus.reg_wdata = wdata_reg;
  assign bus.reg_waddr = waddr_reg;
  assign bus.reg_wen   = wen_reg;
  assign bus.illegal   = illegal_reg;

  // Kept in its own expression so the arithmetic shift is not forced unsigned.
  assign sra_result = $signed(op_a) >>> shamt;

  // Single-cycle result; unsupported opcodes produce zero.
  always_comb begin
    alu_result = '0;
    if (opcode == OPC_LUI) begin
      alu_result = op_b;
    end else if (opcode == OPC_AUIPC) begin
      alu_result = bus.instr_addr + op_b;
    end else if (is_alu) begin
      case (funct3)
        3'b000:  alu_result = ((opcode == OPC_OP) && alt) ? (op_a - op_b) : (op_a + op_b);
        3'b001:  alu_result = op_a << shamt;
        3'b010:  alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        3'b011:  alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
        3'b100:  alu_result = op_a ^ op_b;
        3'b101:  alu_result = alt ? sra_result : (op_a >> shamt);
        3'b110:  alu_result = op_a | op_b;
        default: alu_result = op_a & op_b;
      endcase
    end
  end

  // One bit of iterative shift applied to the operand held in the result register.
  always_comb begin
    shift_step = wdata_reg;
    if (shift_left_reg) begin
      shift_step = {wdata_reg[XLEN-2:0], 1'b0};
    end else begin
      shift_step = {shift_arith_reg & wdata_reg[XLEN-1], wdata_reg[XLEN-1:1]};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; flush overrides everything, including a pending accept.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) state_next = iterative ? SHIFT : OUT;
        end
        SHIFT: begin
          if (count_reg <= SHW'(1)) state_next = OUT;
        end
        OUT: begin
          if (accept) begin
            state_next = iterative ? SHIFT : OUT;
          end else if (bus.out_ready) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Result registers: load on accept, step during SHIFT, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_reg       <= '0;
      waddr_reg       <= '0;
      wen_reg         <= 1'b0;
      illegal_reg     <= 1'b0;
      count_reg       <= '0;
      shift_left_reg  <= 1'b0;
      shift_arith_reg <= 1'b0;
    end else if (flush) begin
      count_reg <= '0;
    end else if (accept) begin
      waddr_reg       <= rd;
      wen_reg         <= bus.reg_wen_in && legal && (rd != 5'd0);
      illegal_reg     <= !legal;
      shift_left_reg  <= (funct3 == 3'b001);
      shift_arith_reg <= alt;
      count_reg       <= iterative ? shamt : '0;
      wdata_reg       <= iterative ? op_a : alu_result;
    end else if (state_reg == SHIFT) begin
      wdata_reg <= shift_step;
      count_reg <= count_reg - SHW'(1);
    end
  end
endmodule
